pwm_duty_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ctrl_pkg.sv | 25 ++
 rtl/pwm_step_timer.sv | 34 +++
 rtl/pwm_duty_ramp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty-ramp controller.
//   state_t      : controller states (IDLE, HI, LO)
//   DEF_DUTY_W   : default width of duty values
//   DEF_DUTY_MAX : default highest duty step (10 = 100 %)
//   sat_step()   : +1 / -1 on a duty value, saturating to 0..duty_max
package pwm_ctrl_pkg;

    localparam int DEF_DUTY_W   = 4;
    localparam int DEF_DUTY_MAX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    // The shadow must never wrap: a step past either end stays at the end.
    function automatic int sat_step(input int duty, input logic up, input int duty_max);
        if (up) begin
            return (duty >= duty_max) ? duty_max : duty + 1;
        end
        return (duty <= 0) ? 0 : duty - 1;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Loadable down-counter that times the high and low phases of each step.
//   clk      : clock
//   rst      : synchronous active-high reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : phase length in cycles, >= 1
//   expire   : high during the last cycle of the loaded phase
module pwm_step_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // A phase loaded with N reads N, N-1, ..., 1, so count==1 is its last cycle.
    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Sequences the PWM generator's increase/decrease step inputs. A host target
// (clamped to DUTY_MAX) or a single manual step becomes a train of pulses,
// each PULSE_HI cycles high followed by PULSE_LO cycles low, while a shadow
// copy of the generator's duty is kept in step.
//   clk, rst                        : clock, synchronous active-high reset
//   tgt_valid/tgt_ready/tgt_duty    : host target handshake (ready == IDLE)
//   step_up, step_dn                : manual single-step requests (IDLE only)
//   abort                           : stop after the step in progress
//   increase_duty, decrease_duty    : generator step inputs (never both high)
//   duty_shadow                     : tracked duty
//   busy                            : not in IDLE
//   done                            : one-cycle completion pulse
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int DUTY_INIT = 5,
    parameter int PULSE_HI  = 2,
    parameter int PULSE_LO  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              step_up,
    input  logic              step_dn,
    input  logic              abort,
    output logic              increase_duty,
    output logic              decrease_duty,
    output logic [DUTY_W-1:0] duty_shadow,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);
    localparam logic [CNT_W-1:0]  HI_LEN = CNT_W'(PULSE_HI);
    localparam logic [CNT_W-1:0]  LO_LEN = CNT_W'(PULSE_LO);

    state_t            state;
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] target;
    logic              dir_up;
    logic              abort_flag;
    logic              inc_q;
    logic              dec_q;
    logic              done_q;

    logic [DUTY_W-1:0] clamped;
    logic [DUTY_W-1:0] shadow_up;
    logic [DUTY_W-1:0] shadow_dn;
    logic              tgt_moves;
    logic              up_take;
    logic              dn_take;
    logic              ramp_end;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_expire;

    assign clamped   = (tgt_duty > MAX_D) ? MAX_D : tgt_duty;
    assign shadow_up = DUTY_W'(sat_step(int'(shadow), 1'b1, DUTY_MAX));
    assign shadow_dn = DUTY_W'(sat_step(int'(shadow), 1'b0, DUTY_MAX));
    assign tgt_moves = tgt_valid && (clamped != shadow);

    // Manual steps lose to a target in the same cycle, cancel each other when
    // both are high, and are dropped when they would saturate.
    assign up_take = !tgt_valid && step_up && !step_dn && (shadow < MAX_D);
    assign dn_take = !tgt_valid && step_dn && !step_up && (shadow != '0);

    // Evaluated on the last LO cycle; an abort arriving in that very cycle
    // still stops the ramp.
    assign ramp_end = (shadow == target) || abort_flag || abort;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HI_LEN;
        case (state)
            IDLE: tmr_load = tgt_moves || up_take || dn_take;
            HI: begin
                tmr_load = tmr_expire;
                tmr_val  = LO_LEN;
            end
            LO:      tmr_load = tmr_expire && !ramp_end;
            default: tmr_load = 1'b0;
        endcase
    end

    pwm_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= INIT_D;
            target     <= INIT_D;
            dir_up     <= 1'b0;
            abort_flag <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        if (clamped == shadow) begin
                            done_q <= 1'b1;
                        end else begin
                            target <= clamped;
                            dir_up <= (clamped > shadow);
                            inc_q  <= (clamped > shadow);
                            dec_q  <= (clamped < shadow);
                            state  <= HI;
                        end
                    end else if (up_take) begin
                        target <= shadow_up;
                        dir_up <= 1'b1;
                        inc_q  <= 1'b1;
                        state  <= HI;
                    end else if (dn_take) begin
                        target <= shadow_dn;
                        dir_up <= 1'b0;
                        dec_q  <= 1'b1;
                        state  <= HI;
                    end
                end
                HI: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                    end
                    // The generator registers the step as the pulse ends, so
                    // the shadow moves at the same moment.
                    if (tmr_expire) begin
                        shadow <= dir_up ? shadow_up : shadow_dn;
                        inc_q  <= 1'b0;
                        dec_q  <= 1'b0;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (tmr_expire) begin
                        if (ramp_end) begin
                            abort_flag <= 1'b0;
                            done_q     <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            inc_q <= dir_up;
                            dec_q <= !dir_up;
                            state <= HI;
                        end
                    end
                end
                default: begin
                    inc_q <= 1'b0;
                    dec_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tgt_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign increase_duty = inc_q;
    assign decrease_duty = dec_q;
    assign duty_shadow   = shadow;
    assign done          = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl. The driver predicts each request's
// outcome (pulse count, direction, final duty, done cycle) from the ramp
// rules and queues it; the monitor checks pulses and done against the queue.
module tb_pwm_duty_ramp_ctrl;

    localparam int DUTY_W    = 4;
    localparam int DUTY_MAX  = 10;
    localparam int DUTY_INIT = 5;
    localparam int PULSE_HI  = 2;
    localparam int PULSE_LO  = 2;
    localparam int PERIOD    = PULSE_HI + PULSE_LO;

    typedef enum int {K_TGT, K_UP, K_DN, K_BOTH, K_TGT_STEP} kind_t;

    typedef struct {
        int start_sh;
        bit up;
        int pulses;
        int done_cyc;
        int end_sh;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              tgt_valid;
    logic              tgt_ready;
    logic [DUTY_W-1:0] tgt_duty;
    logic              step_up;
    logic              step_dn;
    logic              abort;
    logic              increase_duty;
    logic              decrease_duty;
    logic [DUTY_W-1:0] duty_shadow;
    logic              busy;
    logic              done;

    pwm_duty_ramp_ctrl #(
        .DUTY_W    (DUTY_W),
        .DUTY_MAX  (DUTY_MAX),
        .DUTY_INIT (DUTY_INIT),
        .PULSE_HI  (PULSE_HI),
        .PULSE_LO  (PULSE_LO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tgt_valid     (tgt_valid),
        .tgt_ready     (tgt_ready),
        .tgt_duty      (tgt_duty),
        .step_up       (step_up),
        .step_dn       (step_dn),
        .abort         (abort),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .duty_shadow   (duty_shadow),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, written by the driver only.
    int   m_shadow;
    int   m_start;
    int   m_free;
    bit   mon_en;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int hi_len     = 0;
    int mon_pulses = 0;
    bit hi_up      = 1'b0;

    always @(negedge clk) begin
        bit   exp_busy;
        exp_t it;
        if (rst) begin
            hi_len     = 0;
            mon_pulses = 0;
        end else if (mon_en) begin
            exp_busy = (cyc > m_start) && (cyc < m_free);
            check("busy", int'(busy), int'(exp_busy));
            check("tgt_ready", int'(tgt_ready), int'(!exp_busy));
            check("both_steps_high", int'(increase_duty && decrease_duty), 0);

            if (increase_duty || decrease_duty) begin
                if (hi_len == 0) hi_up = increase_duty;
                hi_len++;
            end else if (hi_len > 0) begin
                check("queue_depth_at_pulse", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    it = exp_q[0];
                    mon_pulses++;
                    check("pulse_width", hi_len, PULSE_HI);
                    check("pulse_dir", int'(hi_up), int'(it.up));
                    check("shadow_after_pulse", int'(duty_shadow),
                          it.up ? it.start_sh + mon_pulses : it.start_sh - mon_pulses);
                end
                hi_len = 0;
            end

            if (done) begin
                check("item_pending_at_done", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("done_cycle", cyc, it.done_cyc);
                    check("pulse_count", mon_pulses, it.pulses);
                    check("final_shadow", int'(duty_shadow), it.end_sh);
                end
                mon_pulses = 0;
            end
        end
    end

    // Issue one request once the model says the controller is idle, queue its
    // predicted outcome, then optionally pulse abort / a dropped step_up at
    // given cycles relative to the acceptance cycle (-1 = never).
    task automatic run_txn(input kind_t kind, input int duty, input int abort_rel, input int drop_rel);
        int   n;
        int   s;
        int   t;
        int   k;
        int   kk;
        bit   acc;
        bit   up;
        exp_t it;
        while (cyc < m_free) next_cycle();
        n   = cyc;
        s   = m_shadow;
        acc = 1'b0;
        up  = 1'b0;
        k   = 0;
        tgt_duty = DUTY_W'(duty);
        case (kind)
            K_TGT, K_TGT_STEP: begin
                tgt_valid = 1'b1;
                if (kind == K_TGT_STEP) begin
                    if ($urandom_range(0, 1) == 1) step_up = 1'b1;
                    else step_dn = 1'b1;
                end
                t   = (duty > DUTY_MAX) ? DUTY_MAX : duty;
                acc = 1'b1;
                up  = (t > s);
                k   = (t > s) ? t - s : s - t;
            end
            K_UP: begin
                step_up = 1'b1;
                if (s < DUTY_MAX) begin
                    acc = 1'b1;
                    up  = 1'b1;
                    k   = 1;
                end
            end
            K_DN: begin
                step_dn = 1'b1;
                if (s > 0) begin
                    acc = 1'b1;
                    k   = 1;
                end
            end
            default: begin
                step_up = 1'b1;
                step_dn = 1'b1;
            end
        endcase
        abort = (abort_rel == 0);
        if (acc) begin
            kk = k;
            // An abort during step j lets step j finish, then stops.
            if (abort_rel >= 1 && abort_rel <= k * PERIOD) kk = (abort_rel + PERIOD - 1) / PERIOD;
            it.start_sh = s;
            it.up       = up;
            it.pulses   = kk;
            it.done_cyc = n + kk * PERIOD + 1;
            it.end_sh   = up ? s + kk : s - kk;
            exp_q.push_back(it);
            m_start  = n;
            m_free   = it.done_cyc;
            m_shadow = it.end_sh;
        end
        next_cycle();
        tgt_valid = 1'b0;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        abort     = 1'b0;
        while (cyc < m_free) begin
            abort   = (abort_rel > 0) && (cyc == n + abort_rel);
            step_up = (drop_rel > 0) && (cyc == n + drop_rel);
            next_cycle();
        end
        abort   = 1'b0;
        step_up = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_duty  = '0;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        abort     = 1'b0;
        mon_en    = 1'b0;
        m_shadow  = DUTY_INIT;
        m_start   = 0;
        m_free    = 0;

        // Reset values.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_shadow", int'(duty_shadow), DUTY_INIT);
        check("reset_increase", int'(increase_duty), 0);
        check("reset_decrease", int'(decrease_duty), 0);
        check("reset_tgt_ready", int'(tgt_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        next_cycle();
        rst     = 1'b0;
        m_start = cyc;
        m_free  = cyc;
        mon_en  = 1'b1;

        // Directed scenarios.
        run_txn(K_TGT, 8, -1, -1);        // 5 -> 8, three pulses
        run_txn(K_TGT, 15, -1, -1);       // clamped to 10
        run_txn(K_UP, 0, -1, -1);         // saturated at 10: ignored
        run_txn(K_DN, 0, -1, -1);         // 10 -> 9
        run_txn(K_BOTH, 0, -1, -1);       // both steps: ignored
        run_txn(K_TGT, 0, -1, -1);        // 9 -> 0
        run_txn(K_DN, 0, -1, -1);         // saturated at 0: ignored
        run_txn(K_UP, 0, -1, -1);         // 0 -> 1
        run_txn(K_TGT_STEP, 7, -1, 3);    // target wins, mid-ramp step dropped
        run_txn(K_TGT, 5, -1, -1);        // 7 -> 5
        run_txn(K_TGT, 10, 6, -1);        // abort during second step: ends at 7
        run_txn(K_TGT, 7, -1, -1);        // equal target: done next cycle
        run_txn(K_TGT, 2, 0, -1);         // abort in IDLE has no effect

        // Randomised requests.
        for (int i = 0; i < 80; i++) begin
            int ab;
            int dr;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
            dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : -1;
            run_txn(kind_t'($urandom_range(0, 4)), int'($urandom_range(0, 15)), ab, dr);
        end

        // Reset in the middle of a ramp.
        while (cyc < m_free) next_cycle();
        next_cycle();
        mon_en    = 1'b0;
        tgt_duty  = (m_shadow >= DUTY_INIT) ? DUTY_W'(0) : DUTY_W'(DUTY_MAX);
        tgt_valid = 1'b1;
        next_cycle();
        tgt_valid = 1'b0;
        rst       = 1'b1;
        next_cycle();
        @(negedge clk);
        check("midramp_reset_increase", int'(increase_duty), 0);
        check("midramp_reset_decrease", int'(decrease_duty), 0);
        check("midramp_reset_shadow", int'(duty_shadow), DUTY_INIT);
        check("midramp_reset_busy", int'(busy), 0);
        next_cycle();
        rst      = 1'b0;
        exp_q.delete();
        m_shadow = DUTY_INIT;
        m_start  = cyc;
        m_free   = cyc;
        mon_en   = 1'b1;
        run_txn(K_TGT, 9, -1, -1);
        run_txn(K_DN, 0, -1, -1);

        while (cyc < m_free) next_cycle();
        next_cycle();
        next_cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
